rf_op_sequencer: RTL
====================

Name: rf_op_sequencer

Overview:
- Initiator-side controller for the 8-entry register file (R1–R4, S1–S4): accepts one register-transfer command per valid/ready handshake and sequences the file's control lines (OutASel, FunSel, RegSel, ScrSel, I) over one or more cycles to execute it.
- Sits between the control unit and the register file. Data for loads loops back from the file's OutA through this block onto the file's I input.

Parameters:
- FS_DEC, 3'b000, FunSel code for decrement
- FS_INC, 3'b001, FunSel code for increment
- FS_LOAD, 3'b010, FunSel code for load from I
- FS_CLR, 3'b011, FunSel code for clear

Ports:
- Clock  input  1  rising-edge clock, shared with the register file
- Reset  input  1  asynchronous, active-low reset
- ReqValid  input  1  command valid
- ReqReady  output  1  block can accept a command
- ReqOp  input  2  00 MOVE, 01 SWAP, 10 CLEAR, 11 ADDN
- ReqSrc  input  3  source index
- ReqDst  input  3  destination index
- ReqCount  input  4  increment count for ADDN
- RfOutA  input  16  register file OutA
- I  output  16  to register file I
- OutASel  output  3  to register file
- OutBSel  output  3  to register file, held at 3'b000
- FunSel  output  3  to register file
- RegSel  output  4  to register file, active-low enables
- ScrSel  output  4  to register file, active-low enables
- Busy  output  1  command in progress
- Done  output  1  one-cycle completion pulse
- Err  output  1  valid with Done; command rejected

Behaviour:
- Index map: 0–3 select R1–R4; 4–7 select S1–S4.
- Enabling index n drives RegSel[3-n]=0 for n<4, or ScrSel[7-n]=0 for n≥4. All other enable bits are 1.
- Idle/default outputs: RegSel=ScrSel=4'b1111, FunSel=FS_LOAD, OutASel=0, Busy=0, Done=0, Err=0.
- I = RfOutA at all times (combinational pass-through).
- Reset (async, low): state goes to IDLE and latched fields clear; all outputs take their idle values immediately.
  - Reset mid-command leaves partially written registers as they are; there is no rollback.
- Handshake:
  - ReqReady=1 only in IDLE.
  - Accept on a rising edge with ReqValid&ReqReady. Op, Src, Dst and Count are latched at accept.
  - Input changes after accept are ignored.
- FSM: IDLE, MOVE, SW1, SW2, SW3, CLR, INC, DONE. Control outputs are decoded from the registered state and latched fields (Moore). Each exec state's register write occurs on the edge that ends that state.
  - MOVE (1 cycle): OutASel=Src, FunSel=FS_LOAD, enable Dst. Next state DONE.
  - SWAP uses S4 (index 7) as temp:
    - SW1: OutASel=Src, load into 7.
    - SW2: OutASel=Dst, load into Src.
    - SW3: OutASel=7, load into Dst.
    - Next state DONE.
  - SWAP with Src==7 or Dst==7: no exec states, go directly to DONE with Err=1.
  - SWAP with Src==Dst is legal; the register ends unchanged and S4 ends holding its value.
  - CLR (1 cycle): FunSel=FS_CLR, enable Dst. Next state DONE.
  - ADDN: INC repeats Count cycles with FunSel=FS_INC and Dst enabled. An internal down-counter is loaded with Count at accept.
    - Count==0: go directly to DONE, no write, Err=0.
    - Wrap of the destination register (16'hFFFF+1=0) is the register's behaviour; it is not flagged.
  - MOVE with Src==Dst is legal and rewrites the same value.
  - DONE: Done=1 and Err valid for exactly one cycle, then IDLE.
- Busy=1 in every state except IDLE, including DONE.
- Latency from the accept edge k:
  - MOVE/CLR: write at edge k+1, Done high during cycle k+1→k+2, ReqReady high again after edge k+2.
  - SWAP: 3 writes, Done during k+3→k+4.
  - ADDN: Count writes, Done during k+Count→k+Count+1.
- Back-to-back: next accept is possible at the edge ending the IDLE cycle that follows DONE.

Test Plan:
- Bench instantiates the team RegisterFile; RfOutA and the control outputs are wired through.
- Reset: assert Reset=0 mid-SWAP after SW1 → outputs go idle immediately. R1 and R3 are unchanged; S4 holds the copied value. The next command works normally.
- MOVE: R2=16'h1234, MOVE Src=1 Dst=4 → S1=16'h1234 after 1 write. Done pulses 2 cycles after accept; no other register changes.
- SWAP: R1=16'hAAAA, R3=16'h5555, SWAP Src=0 Dst=2 → R1=16'h5555, R3=16'hAAAA, S4=16'hAAAA. Done pulses 4 cycles after accept.
- SWAP error: Src=7, Dst=0 → no enable is ever low, Done=1 with Err=1, 1 cycle after accept.
- ADDN: R4=16'hFFFE, Count=3 → R4=16'h0001. Count=0 → no write, Done 1 cycle after accept.
- Handshake: hold ReqValid=1 with two queued commands → second accepted only after Done plus one IDLE cycle. ReqReady=0 throughout Busy; CLEAR Dst=5 → S2=0.

Source files
------------

// File: rtl/rf_op_sequencer.sv
// Command sequencer for the 8-entry register file: takes one MOVE/SWAP/CLEAR/ADDN
// command per handshake and drives the file's control lines cycle by cycle.
module rf_op_sequencer #(
  parameter logic [2:0] FS_DEC  = 3'b000,
  parameter logic [2:0] FS_INC  = 3'b001,
  parameter logic [2:0] FS_LOAD = 3'b010,
  parameter logic [2:0] FS_CLR  = 3'b011
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [1:0]  ReqOp,
  input  logic [2:0]  ReqSrc,
  input  logic [2:0]  ReqDst,
  input  logic [3:0]  ReqCount,
  input  logic [15:0] RfOutA,
  output logic [15:0] I,
  output logic [2:0]  OutASel,
  output logic [2:0]  OutBSel,
  output logic [2:0]  FunSel,
  output logic [3:0]  RegSel,
  output logic [3:0]  ScrSel,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [2:0]  StateDbg
);

  // Handshake: a command is taken on a rising Clock edge where ReqValid and
  // ReqReady are both 1; ReqReady is 1 only in IDLE, fields are latched then.

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SW1, S_SW2, S_SW3, S_CLR, S_INC, S_DONE
  } state_t;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_SWAP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_ADDN  = 2'b11;
  localparam logic [2:0] TMP_IDX  = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  src_q, src_d;
  logic [2:0]  dst_q, dst_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rej_q, rej_d;
  logic        ready_q, ready_d;
  logic [2:0]  oasel_q, oasel_d;
  logic [2:0]  fsel_q, fsel_d;
  logic [7:0]  en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // {RegSel, ScrSel} as one active-low vector: index n lives at bit 7-n.
  function automatic logic [7:0] en_mask(input logic [2:0] idx);
    return ~(8'h80 >> idx);
  endfunction

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    rej_d   = rej_q;
    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          src_d = ReqSrc;
          dst_d = ReqDst;
          cnt_d = ReqCount;
          rej_d = 1'b0;
          case (ReqOp)
            OP_MOVE:  state_d = S_MOVE;
            OP_SWAP: begin
              if (ReqSrc == TMP_IDX || ReqDst == TMP_IDX) begin
                rej_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_SW1;
              end
            end
            OP_CLEAR: state_d = S_CLR;
            OP_ADDN:  state_d = (ReqCount == 4'd0) ? S_DONE : S_INC;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_SW1:   state_d = S_SW2;
      S_SW2:   state_d = S_SW3;
      S_MOVE, S_SW3, S_CLR: state_d = S_DONE;
      S_INC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        rej_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    oasel_d = 3'd0;
    fsel_d  = FS_LOAD;
    en_d    = 8'hFF;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      S_MOVE: begin
        oasel_d = src_d;
        en_d    = en_mask(dst_d);
      end
      S_SW1: begin
        oasel_d = src_d;
        en_d    = en_mask(TMP_IDX);
      end
      S_SW2: begin
        oasel_d = dst_d;
        en_d    = en_mask(src_d);
      end
      S_SW3: begin
        oasel_d = TMP_IDX;
        en_d    = en_mask(dst_d);
      end
      S_CLR: begin
        fsel_d = FS_CLR;
        en_d   = en_mask(dst_d);
      end
      S_INC: begin
        fsel_d = FS_INC;
        en_d   = en_mask(dst_d);
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = rej_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      src_q   <= 3'd0;
      dst_q   <= 3'd0;
      cnt_q   <= 4'd0;
      rej_q   <= 1'b0;
      ready_q <= 1'b1;
      oasel_q <= 3'd0;
      fsel_q  <= FS_LOAD;
      en_q    <= 8'hFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      rej_q   <= rej_d;
      ready_q <= ready_d;
      oasel_q <= oasel_d;
      fsel_q  <= fsel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign I        = RfOutA;
  assign ReqReady = ready_q;
  assign OutASel  = oasel_q;
  assign OutBSel  = 3'b000;
  assign FunSel   = fsel_q;
  assign RegSel   = en_q[7:4];
  assign ScrSel   = en_q[3:0];
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign StateDbg = state_q;

endmodule
